// File: rtl/matrix_mac_seq.sv
// Sequential Q0.DW matrix-vector multiplier: LANES products per accepted chunk, one saturated result per row.
// Result is registered 1 cycle after a row's last chunk; row_ready_o is high throughout RUN, outputs have no backpressure.
module matrix_mac_seq #(
   parameter int DW    = 16,
   parameter int N     = 64,
   parameter int LANES = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic                  rnd_i,
   input  logic [N*DW-1:0]       vec_in_i,
   input  logic                  row_valid_i,
   output logic                  row_ready_o,
   input  logic [LANES*DW-1:0]   row_data_i,
   output logic                  out_valid_o,
   output logic [DW-1:0]         out_data_o,
   output logic                  out_sat_o,
   output logic                  out_last_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  sat_any_o
);

   localparam int CHUNKS = N / LANES;
   localparam int AW     = DW + $clog2(N);
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int RW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [2*DW-1:0] HALF = (2*DW)'(1) << (DW-1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q;
   logic [N*DW-1:0]   vec_q;
   logic              rnd_q;
   logic [AW-1:0]     acc_q;
   logic [CW-1:0]     chunk_q;
   logic [RW-1:0]     row_q;
   logic              out_valid_q;
   logic [DW-1:0]     out_data_q;
   logic              out_sat_q;
   logic              out_last_q;
   logic              done_q;
   logic              sat_any_q;

   logic [AW-1:0]     acc_d;
   logic [DW-1:0]     a_lane;
   logic [DW-1:0]     b_lane;
   logic [2*DW-1:0]   prod;
   logic              sat_d;
   logic              row_end;
   logic              last_row;

   // Lane k multiplies A[chunk*LANES+k]; products are reduced to Q0.DW before accumulation.
   always_comb begin
      acc_d  = acc_q;
      a_lane = '0;
      b_lane = '0;
      prod   = '0;
      for (int k = 0; k < LANES; k++) begin
         a_lane = vec_q[(int'(chunk_q) * LANES + k) * DW +: DW];
         b_lane = row_data_i[k*DW +: DW];
         prod   = (2*DW)'(a_lane) * (2*DW)'(b_lane);
         if (rnd_q) begin
            prod = prod + HALF;
         end
         acc_d = acc_d + AW'(prod >> DW);
      end
   end

   assign sat_d    = |acc_d[AW-1:DW];
   assign row_end  = (chunk_q == CW'(CHUNKS-1));
   assign last_row = (row_q == RW'(N-1));

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         rnd_q       <= 1'b0;
         acc_q       <= '0;
         chunk_q     <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         sat_any_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  vec_q     <= vec_in_i;
                  rnd_q     <= rnd_i;
                  acc_q     <= '0;
                  chunk_q   <= '0;
                  row_q     <= '0;
                  sat_any_q <= 1'b0;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (row_valid_i) begin
                  if (!row_end) begin
                     acc_q   <= acc_d;
                     chunk_q <= chunk_q + CW'(1);
                  end else begin
                     out_data_q  <= sat_d ? {DW{1'b1}} : acc_d[DW-1:0];
                     out_sat_q   <= sat_d;
                     sat_any_q   <= sat_any_q | sat_d;
                     out_valid_q <= 1'b1;
                     out_last_q  <= last_row;
                     acc_q       <= '0;
                     chunk_q     <= '0;
                     if (last_row) begin
                        done_q  <= 1'b1;
                        row_q   <= '0;
                        state_q <= IDLE;
                     end else begin
                        row_q <= row_q + RW'(1);
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign row_ready_o = (state_q == RUN);
   assign busy_o      = (state_q == RUN);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;
   assign out_last_o  = out_last_q;
   assign done_o      = done_q;
   assign sat_any_o   = sat_any_q;

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Directed bench: small N=4/LANES=2 instance for hand-computed cases, default 64x64/LANES=4 instance against a reference sum.
module tb_matrix_mac_seq;

   logic clk;
   int   n_cmp = 0;
   int   n_mis = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic        s_reset, s_start_i, s_rnd, s_row_valid, s_ready;
   logic [63:0] s_vec;
   logic [31:0] s_row_data;
   logic        s_out_valid, s_out_sat, s_out_last, s_busy, s_done, s_sat_any;
   logic [15:0] s_out_data;
   logic [15:0] s_last_data;

   matrix_mac_seq #(.DW(16), .N(4), .LANES(2)) u_small (
      .clock_i(clk), .reset_i(s_reset), .start_i(s_start_i), .rnd_i(s_rnd),
      .vec_in_i(s_vec), .row_valid_i(s_row_valid), .row_ready_o(s_ready),
      .row_data_i(s_row_data), .out_valid_o(s_out_valid), .out_data_o(s_out_data),
      .out_sat_o(s_out_sat), .out_last_o(s_out_last), .busy_o(s_busy),
      .done_o(s_done), .sat_any_o(s_sat_any));

   // default-size instance
   logic          b_reset, b_start_i, b_rnd, b_row_valid, b_ready;
   logic [1023:0] b_vec;
   logic [63:0]   b_row_data;
   logic          b_out_valid, b_out_sat, b_out_last, b_busy, b_done, b_sat_any;
   logic [15:0]   b_out_data;
   logic [15:0]   bA [64];
   logic [15:0]   bB [64][64];

   matrix_mac_seq u_big (
      .clock_i(clk), .reset_i(b_reset), .start_i(b_start_i), .rnd_i(b_rnd),
      .vec_in_i(b_vec), .row_valid_i(b_row_valid), .row_ready_o(b_ready),
      .row_data_i(b_row_data), .out_valid_o(b_out_valid), .out_data_o(b_out_data),
      .out_sat_o(b_out_sat), .out_last_o(b_out_last), .busy_o(b_busy),
      .done_o(b_done), .sat_any_o(b_sat_any));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic s_check_idle(input string tag);
      check({tag, "_ready"},     s_ready,     0);
      check({tag, "_busy"},      s_busy,      0);
      check({tag, "_out_valid"}, s_out_valid, 0);
      check({tag, "_out_data"},  s_out_data,  0);
      check({tag, "_out_sat"},   s_out_sat,   0);
      check({tag, "_out_last"},  s_out_last,  0);
      check({tag, "_done"},      s_done,      0);
      check({tag, "_sat_any"},   s_sat_any,   0);
   endtask

   task automatic s_start(input logic [63:0] vec, input logic r);
      s_start_i = 1'b1;
      s_vec     = vec;
      s_rnd     = r;
      @(posedge clk); #1;
      s_start_i = 1'b0;
      check("start_busy",    s_busy,    1);
      check("start_ready",   s_ready,   1);
      check("start_sat_clr", s_sat_any, 0);
   endtask

   // Sends one row as two chunks, optionally with idle gaps before each chunk.
   task automatic s_row(input logic [63:0] row, input logic [15:0] exp, input logic esat,
                        input logic elast, input int gaps);
      for (int c = 0; c < 2; c++) begin
         for (int g = 0; g < gaps; g++) begin
            s_row_valid = 1'b0;
            @(posedge clk); #1;
            check("gap_out_valid", s_out_valid, 0);
            check("gap_out_hold",  s_out_data,  s_last_data);
         end
         s_row_valid = 1'b1;
         s_row_data  = row[c*32 +: 32];
         check("row_ready", s_ready, 1);
         @(posedge clk); #1;
         if (c == 0) check("mid_out_valid", s_out_valid, 0);
      end
      s_row_valid = 1'b0;
      check("out_valid", s_out_valid, 1);
      check("out_data",  s_out_data,  exp);
      check("out_sat",   s_out_sat,   esat);
      check("out_last",  s_out_last,  elast);
      check("done",      s_done,      elast);
      if (elast) begin
         check("done_busy",  s_busy,  0);
         check("done_ready", s_ready, 0);
      end
      s_last_data = exp;
   endtask

   localparam logic [63:0] V_SAT   = 64'h8000_8000_8000_8000;
   localparam logic [63:0] V_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] R_ONE   = 64'h0001_0001_0001_0001;
   localparam logic [63:0] V_MIX   = 64'h0000_0000_4000_4000;

   initial begin
      longint     sum;
      logic [15:0] exp_d;
      logic        exp_s;

      s_reset = 1'b1; s_start_i = 1'b0; s_rnd = 1'b0; s_row_valid = 1'b0;
      s_vec = '0; s_row_data = '0; s_last_data = '0;
      b_reset = 1'b1; b_start_i = 1'b0; b_rnd = 1'b0; b_row_valid = 1'b0;
      b_vec = '0; b_row_data = '0;
      repeat (2) @(posedge clk);
      #1;
      s_reset = 1'b0; b_reset = 1'b0;
      s_check_idle("reset");
      check("big_reset_ready", b_ready, 0);

      // saturating job, back-to-back rows
      s_start(V_SAT, 1'b0);
      for (int r = 0; r < 4; r++) s_row(V_SAT, 16'hFFFF, 1'b1, r == 3, 0);
      check("sat_any_set", s_sat_any, 1);

      // truncate job started in the done cycle; sticky flag must clear
      s_start(V_ONES, 1'b0);
      for (int r = 0; r < 4; r++) s_row(R_ONE, 16'h0000, 1'b0, r == 3, 0);
      check("sat_any_trunc", s_sat_any, 0);

      // round job with gaps; start and rnd wiggled mid-job must be ignored
      s_start(V_ONES, 1'b1);
      s_row(R_ONE, 16'h0004, 1'b0, 1'b0, 2);
      s_start_i = 1'b1; s_vec = V_SAT; s_rnd = 1'b0;
      s_row(R_ONE, 16'h0004, 1'b0, 1'b0, 1);
      s_start_i = 1'b0;
      s_row(R_ONE, 16'h0004, 1'b0, 1'b0, 2);
      s_row(R_ONE, 16'h0004, 1'b0, 1'b1, 1);
      check("sat_any_round", s_sat_any, 0);
      @(posedge clk); #1;
      check("idle_ready", s_ready, 0);
      check("idle_busy",  s_busy,  0);

      // reset after three chunks; reset beats start and handshake in the same cycle
      s_start(V_SAT, 1'b0);
      s_row(V_SAT, 16'hFFFF, 1'b1, 1'b0, 0);
      s_row_valid = 1'b1; s_row_data = V_SAT[31:0];
      @(posedge clk); #1;
      s_reset = 1'b1; s_start_i = 1'b1;
      @(posedge clk); #1;
      s_reset = 1'b0; s_start_i = 1'b0; s_row_valid = 1'b0;
      s_check_idle("midreset");
      s_last_data = '0;
      @(posedge clk); #1;
      check("midreset_out_valid", s_out_valid, 0);
      check("midreset_busy",      s_busy,      0);

      // mixed values, fresh accumulator
      s_start(V_MIX, 1'b0);
      s_row(64'hFFFF_FFFF_4000_4000, 16'h2000, 1'b0, 1'b0, 1);
      s_row(64'h5678_1234_0000_FFFF, 16'h3FFF, 1'b0, 1'b0, 0);
      s_row(64'h5555_AAAA_8000_8000, 16'h4000, 1'b0, 1'b0, 1);
      s_row(64'h0001_0002_FFFF_FFFF, 16'h7FFE, 1'b0, 1'b1, 0);
      check("mix_sat_any", s_sat_any, 0);

      // 64x64 random job, round mode, per-row magnitude varied to mix saturated/unsaturated rows
      for (int j = 0; j < 64; j++) begin
         bA[j] = 16'($urandom);
         b_vec[j*16 +: 16] = bA[j];
         for (int r = 0; r < 64; r++) bB[r][j] = 16'($urandom) & (16'hFFFF >> (r % 8));
      end
      b_start_i = 1'b1; b_rnd = 1'b1;
      @(posedge clk); #1;
      b_start_i = 1'b0; b_rnd = 1'b0;
      check("big_busy", b_busy, 1);
      for (int r = 0; r < 64; r++) begin
         sum = 0;
         for (int j = 0; j < 64; j++)
            sum = sum + ((longint'(bA[j]) * longint'(bB[r][j]) + 64'd32768) >> 16);
         exp_s = (sum > 65535);
         exp_d = exp_s ? 16'hFFFF : sum[15:0];
         for (int c = 0; c < 16; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               b_row_valid = 1'b0;
               @(posedge clk); #1;
            end
            b_row_valid = 1'b1;
            for (int k = 0; k < 4; k++) b_row_data[k*16 +: 16] = bB[r][c*4 + k];
            @(posedge clk); #1;
         end
         b_row_valid = 1'b0;
         check("big_out_valid", b_out_valid, 1);
         check("big_out_data",  b_out_data,  exp_d);
         check("big_out_sat",   b_out_sat,   exp_s);
         check("big_out_last",  b_out_last,  r == 63);
      end
      check("big_done", b_done, 1);
      check("big_idle", b_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/matrix_mac_seq.md
# matrix_mac_seq

Parametrised, sequential fixed-point matrix-vector multiplier: y[r] = sat(Σ_j q(A[j]·B[r][j])) for r = 0..N-1, with unsigned Q0.DW operands. The input vector is latched on `start`; matrix rows are streamed in LANES-wide chunks over a valid/ready handshake; one saturated DW-bit result is emitted per row. It is the datapath stage between the coefficient buffer and the output formatter, replacing the fixed 64×64, fully combinational multiplier. It adds runtime round/truncate selection, saturation reporting and multiplier sharing.

## Interface
- DW, 16: operand and result width (unsigned fractional Q0.DW)
- N, 64: vector length = row length = number of rows; must be a multiple of LANES
- LANES, 4: multipliers instantiated; matrix elements consumed per handshake
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- rnd  in  1  sampled with start: 0 = truncate products, 1 = round half-up
- vec_in  in  N*DW  vector A; element j at [j*DW +: DW]; sampled on accepted start
- row_valid  in  1  row_data holds a valid chunk
- row_ready  out  1  block accepts a chunk this cycle
- row_data  in  LANES*DW  chunk; lane k at [k*DW +: DW]
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  DW  saturated row result
- out_sat  out  1  qualifies out_valid: this row saturated
- out_last  out  1  qualifies out_valid: final row (r = N-1)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, coincident with the final out_valid
- sat_any  out  1  sticky: any row of the current/last job saturated; cleared on accepted start

## Operation
- States: IDLE, RUN. Counters: chunk_cnt (0..N/LANES-1), row_cnt (0..N-1). Accumulator acc is DW+clog2(N) bits.
- IDLE, start=1: latch vec_in and rnd, clear acc, chunk_cnt, row_cnt and sat_any, then go to RUN.
- start is ignored in RUN. `rnd` changes after acceptance have no effect.
- RUN: row_ready=1. A handshake is row_valid && row_ready. Chunk c of row r carries elements j = c*LANES+k for k = 0..LANES-1.
- Per lane: p_k = A[j]·row_data_k, full 2DW-bit product.
  - Truncate mode: t_k = p_k >> DW.
  - Round mode: t_k = (p_k + 2^(DW-1)) >> DW. This cannot overflow 2DW bits.
- On each handshake: s = acc + Σ t_k.
  - If chunk_cnt < N/LANES-1: acc <= s, chunk_cnt++.
  - If chunk_cnt = N/LANES-1 (row end):
    - out_data <= (s > 2^DW-1) ? all-ones : s[DW-1:0]
    - out_sat <= (s > 2^DW-1); sat_any |= out_sat
    - out_valid <= 1; acc <= 0; chunk_cnt <= 0
    - If row_cnt = N-1: out_last <= 1, done <= 1, return to IDLE. Otherwise row_cnt++.
- No handshake in a cycle: all state holds.
- Output has no backpressure. The consumer must always accept out_valid.
- out_data, out_sat and out_last hold their values until the next out_valid. out_last is cleared at the next out_valid or on reset.

## Timing
- reset=1 at a clock edge gives: IDLE, row_ready=0, busy=0, out_valid=0, out_data=0, out_sat=0, out_last=0, done=0, sat_any=0, acc=0, counters=0.
- Reset mid-job discards partial sums. No out_valid or done is produced for the aborted job.
- Reset takes priority over start and over a handshake in the same cycle.
- busy and row_ready rise the cycle after an accepted start.
- Latency: out_valid is asserted exactly 1 cycle after the row's final chunk handshake.
- Throughput: one chunk per cycle. Back-to-back rows have no bubble; the next row's first chunk may be accepted in the same cycle that the previous row's out_valid is high.
- Minimum job length: N·N/LANES handshake cycles.
- done/out_last pulse: busy and row_ready are already 0 in that cycle.
- A new start is accepted in the done cycle, since the block is already in IDLE.

## Test plan
- Saturation (N=4, LANES=2): A = all 0x8000, B = all 0x8000, rnd=0. Each t=0x4000 and the row sum is 0x10000, so expect 4 outputs of 0xFFFF with out_sat=1, sat_any=1, and out_last/done on the 4th output.
- Rounding (N=4, LANES=2): A = all 0xFFFF, B = all 0x0001. Expect 0x0000 with rnd=0 and 0x0004 with rnd=1; out_sat=0 in both cases.
- Mixed values (N=4, LANES=2): A = [0x4000, 0x4000, 0, 0], row 0 = [0x4000, 0x4000, 0xFFFF, 0xFFFF], rnd=0. Expect out_data=0x2000; a random 64×64 job with LANES=4 must match the reference model bit-exactly.
- Handshake: insert random row_valid gaps and also run back-to-back rows. Expect results unchanged and out_valid 1 cycle after each row-end handshake. row_ready must be 0 in IDLE. A start pulsed mid-job must be ignored.
- Reset: assert reset after 3 chunks of row 1. Expect all outputs 0 and IDLE next cycle. A fresh job must then give correct results with no carry-over into acc.
- Sticky flag: a saturating job followed by a non-saturating job. Expect sat_any to clear on the second start and stay 0 for the second job.
